// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU issue slice.
// Select codes, widths and the buffered request record.
package alu_pkg;

   localparam int OP_W      = 4;
   localparam int REQ_N     = 8;
   localparam int REQ_TAG_W = 4;

   localparam logic [OP_W-1:0] OP_ADD  = 4'h0;
   localparam logic [OP_W-1:0] OP_SUB  = 4'h1;
   localparam logic [OP_W-1:0] OP_AND  = 4'h2;
   localparam logic [OP_W-1:0] OP_OR   = 4'h3;
   localparam logic [OP_W-1:0] OP_XOR  = 4'h4;
   localparam logic [OP_W-1:0] OP_NOR  = 4'h5;
   localparam logic [OP_W-1:0] OP_NAND = 4'h6;
   localparam logic [OP_W-1:0] OP_XNOR = 4'h7;
   localparam logic [OP_W-1:0] OP_SLL  = 4'h8;
   localparam logic [OP_W-1:0] OP_SRL  = 4'h9;
   localparam logic [OP_W-1:0] OP_SRA  = 4'hA;
   localparam logic [OP_W-1:0] OP_ROL  = 4'hB;
   localparam logic [OP_W-1:0] OP_ROR  = 4'hC;
   localparam logic [OP_W-1:0] OP_SLT  = 4'hD;
   localparam logic [OP_W-1:0] OP_PASA = 4'hE;
   localparam logic [OP_W-1:0] OP_PASB = 4'hF;

   typedef struct packed {
      logic [REQ_N-1:0]     a;
      logic [REQ_N-1:0]     b;
      logic [OP_W-1:0]      op;
      logic [REQ_TAG_W-1:0] tag;
   } alu_req_t;

endpackage

// File: rtl/alu_req_fifo.sv
// Request FIFO with count-based full/empty.
// Head entry is presented combinationally.
module alu_req_fifo #(
   parameter int W     = 24,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push_i,
   input  logic [W-1:0] wdata_i,
   input  logic         pop_i,
   output logic [W-1:0] head_o,
   output logic         full_o,
   output logic         empty_o
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_q, wr_d;
   logic [AW-1:0] rd_q, rd_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          do_push;
   logic          do_pop;

   assign full_o  = (cnt_q == CW'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;
   assign head_o  = mem[rd_q];

   // Next pointer and occupancy values
   always_comb begin
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q;
      if (do_push) wr_d = wr_q + AW'(1);
      if (do_pop)  rd_d = rd_q + AW'(1);
      unique case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   // Pointer and count registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   // Storage is never cleared; empty masks stale data
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_q] <= wdata_i;
   end

endmodule

// File: rtl/alu_issue_unit.sv
// Buffers ALU requests, issues one per cycle and
// registers each result with its opcode and tag.
module alu_issue_unit
   import alu_pkg::*;
#(
   parameter int N     = 8,
   parameter int DEPTH = 4,
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [N-1:0]     in_a,
   input  logic [N-1:0]     in_b,
   input  logic [OP_W-1:0]  in_op,
   output logic [N-1:0]     alu_a,
   output logic [N-1:0]     alu_b,
   output logic [OP_W-1:0]  alu_select,
   input  logic [N-1:0]     alu_result,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [N-1:0]     out_result,
   output logic [OP_W-1:0]  out_op,
   output logic [TAG_W-1:0] out_tag
);

   localparam int W = 2 * N + OP_W + TAG_W;

   logic [W-1:0]     head;
   logic             full;
   logic             empty;
   logic             push;
   logic             pop;
   logic [TAG_W-1:0] tag_q, tag_d;
   logic             ov_q, ov_d;
   logic [N-1:0]     res_q, res_d;
   logic [OP_W-1:0]  op_q, op_d;
   logic [TAG_W-1:0] otag_q, otag_d;

   logic [N-1:0]     hd_a;
   logic [N-1:0]     hd_b;
   logic [OP_W-1:0]  hd_op;
   logic [TAG_W-1:0] hd_tag;

   assign in_ready = !full;
   assign push     = in_valid && !full;
   assign pop      = !empty && (!ov_q || out_ready);

   assign hd_a   = head[W-1 -: N];
   assign hd_b   = head[W-N-1 -: N];
   assign hd_op  = head[TAG_W+OP_W-1 : TAG_W];
   assign hd_tag = head[TAG_W-1:0];

   alu_req_fifo #(
      .W     (W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push),
      .wdata_i ({in_a, in_b, in_op, tag_q}),
      .pop_i   (pop),
      .head_o  (head),
      .full_o  (full),
      .empty_o (empty)
   );

   // Drive the ALU from the head; zeros while empty
   always_comb begin
      alu_a      = '0;
      alu_b      = '0;
      alu_select = '0;
      if (!empty) begin
         alu_a      = hd_a;
         alu_b      = hd_b;
         alu_select = hd_op;
      end
   end

   // Tag counter and output slot next state
   always_comb begin
      tag_d  = tag_q;
      ov_d   = ov_q;
      res_d  = res_q;
      op_d   = op_q;
      otag_d = otag_q;
      if (push) tag_d = tag_q + TAG_W'(1);
      if (pop) begin
         ov_d   = 1'b1;
         res_d  = alu_result;
         op_d   = hd_op;
         otag_d = hd_tag;
      end else if (out_ready) begin
         ov_d = 1'b0;
      end
   end

   // Tag counter and output slot registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tag_q  <= '0;
         ov_q   <= 1'b0;
         res_q  <= '0;
         op_q   <= '0;
         otag_q <= '0;
      end else begin
         tag_q  <= tag_d;
         ov_q   <= ov_d;
         res_q  <= res_d;
         op_q   <= op_d;
         otag_q <= otag_d;
      end
   end

   assign out_valid  = ov_q;
   assign out_result = res_q;
   assign out_op     = op_q;
   assign out_tag    = otag_q;

endmodule

// File: doc/alu_issue_unit.md
Name: alu_issue_unit

Overview:
- Upstream feeder for the combinational N-bit ALU (operands a, b; 4-bit select; N-bit result).
- Accepts operation requests through a valid/ready handshake and buffers them in a small FIFO.
- Issues one request per cycle to the ALU and registers the returned result with its opcode and a sequence tag.
- Presents the registered result through a valid/ready output handshake, so a combinational ALU can sit in a clocked, back-pressured pipeline.

Parameters:
- N, 8, operand/result width; must match the ALU's N.
- DEPTH, 4, request FIFO entries; power of two, at least 2.
- TAG_W, 4, width of the sequence tag counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  request present.
- in_ready  out  1  request FIFO can accept.
- in_a  in  N  operand A.
- in_b  in  N  operand B.
- in_op  in  4  ALU select code.
- alu_a  out  N  to ALU a.
- alu_b  out  N  to ALU b.
- alu_select  out  4  to ALU select.
- alu_result  in  N  from ALU result (combinational return).
- out_valid  out  1  registered result present.
- out_ready  in  1  consumer accepts result.
- out_result  out  N  registered ALU result.
- out_op  out  4  opcode that produced out_result.
- out_tag  out  TAG_W  sequence number of the request.

Behaviour:
- Interface fixed: one clock, clk; rst_n asynchronous, active-low.
- Reset values, applied immediately on assertion regardless of clk:
  - FIFO pointers and count = 0, so FIFO empty.
  - out_valid = 0; out_result, out_op, out_tag = 0.
  - Tag counter = 0.
  - in_ready = 1.
  - FIFO storage contents need not be cleared.
- Accept: push = in_valid && in_ready. in_ready = !full, registered-count based.
  - When full, no push occurs even if a pop happens in the same cycle; there is no full-bypass.
  - Each pushed entry stores {in_a, in_b, in_op, tag}. The tag counter increments on every push and wraps from 2^TAG_W-1 to 0.
- ALU drive, combinational from the FIFO head:
  - alu_a, alu_b and alu_select equal the head entry when the FIFO is not empty.
  - They are all-zero when the FIFO is empty; no X reaches the ALU.
- Issue:
  - pop = !empty && (!out_valid || out_ready).
  - On pop, the output register captures out_result = alu_result, together with out_op and out_tag from the head entry, and sets out_valid = 1.
  - If !pop && out_ready && out_valid, then out_valid goes to 0 and the data fields hold their last value.
  - If out_valid && !out_ready, all output fields are held stable.
- Latency:
  - A request pushed at edge k is visible at the head after k. With out_ready = 1 it is captured at edge k+1, so out_valid rises after edge k+1.
  - Throughput is one result per cycle.
- Capacity: DEPTH + 1 requests total (FIFO plus output register).
- Simultaneous push and pop when not full: count unchanged, both pointers advance.
- Pointers wrap modulo DEPTH.
- Results leave strictly in acceptance order.
- Width rule: alu_result is taken as-is, N bits. The block does no arithmetic on data; overflow behaviour belongs to the ALU.
- Reset mid-operation:
  - All buffered requests and any pending result are discarded; nothing is replayed.
  - The first request accepted after rst_n deasserts gets tag 0.

Decomposition:
- Shared package alu_pkg holds:
  - OP_W = 4, the select width.
  - Opcode constants for the 16 ALU select codes.
  - A request record typedef {a, b, op, tag}, parameterised via N/TAG_W localparams.
- One sub-module, alu_req_fifo: a synchronous FIFO with count-based full/empty, asynchronous active-low reset and a combinational head output.
- Issue logic and the output register live in alu_issue_unit.

Test Plan:
Bench: N=8, DEPTH=4, TAG_W=4, with alu_result tied to a stub computing alu_a + alu_b mod 256.
- Reset: hold rst_n=0 -> out_valid=0, in_ready=1, alu_a=alu_b=0, alu_select=0, out_tag=0.
- Single op: in_a=8'h05, in_b=8'h03, in_op=4'h2, out_ready=1, pushed at edge 0 -> out_valid=1 after edge 1 with out_result=8'h08, out_op=4'h2, out_tag=0; out_valid=0 after edge 2.
- Backpressure: out_ready=0, in_valid held with a=1..6, b=0 -> exactly 5 accepted and in_ready=0 thereafter; out_result=8'h01 held stable. Then out_ready=1 -> results 1,2,3,4,5 on consecutive cycles with tags 0..4; in_ready returns to 1 one cycle after the first drain.
- Streaming and tag wrap: 20 back-to-back ops, in_valid=out_ready=1 -> in_ready stays 1, 20 consecutive results in order, tags 0..15 then 0..3.
- Overflow pass-through: a=8'hFF, b=8'h01 -> out_result=8'h00; the block adds no saturation.
- Asynchronous reset mid-stream: 3 requests buffered, out_valid=1, rst_n pulsed low between edges -> out_valid=0 and in_ready=1 immediately. After release, the next op with a=8'h10, b=8'h20 yields out_result=8'h30, out_tag=0, and no stale results appear.
